// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline registers.
// Stage-side pack/unpack logic uses the field offsets; the register itself only sees a flat bus.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    localparam int CTRL_W = 40;

    // Control bundle layout, LSB-aligned: imm | mux_b_sel | mux_a_sel | write_ad | cond | alu_op
    localparam int ALU_OP_LSB    = 0;
    localparam int ALU_OP_W      = 6;
    localparam int COND_LSB      = ALU_OP_LSB + ALU_OP_W;
    localparam int COND_W        = 4;
    localparam int WRITE_AD_LSB  = COND_LSB + COND_W;
    localparam int WRITE_AD_W    = 5;
    localparam int MUX_A_SEL_LSB = WRITE_AD_LSB + WRITE_AD_W;
    localparam int MUX_A_SEL_W   = 2;
    localparam int MUX_B_SEL_LSB = MUX_A_SEL_LSB + MUX_A_SEL_W;
    localparam int MUX_B_SEL_W   = 2;
    localparam int IMM_LSB       = MUX_B_SEL_LSB + MUX_B_SEL_W;
    localparam int IMM_W         = CTRL_W - IMM_LSB;

    localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating count of backpressured output cycles; a clear wins over an increment.
module pipe_stall_counter #(
    parameter int STALL_CNT_W = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   stall,
    input  logic                   clr,
    output logic [STALL_CNT_W-1:0] count
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (stall && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stage_register.sv
// Handshaked register between two adjacent pipeline stages, with optional 2-entry skid buffer,
// flush-to-bubble and a saturating stall counter.
module pipeline_stage_register
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 40,
    parameter logic [WIDTH-1:0] NOP_VALUE   = {WIDTH{1'b0}},
    parameter bit               SKID        = 1'b1,
    parameter int               STALL_CNT_W = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    input  logic                   stall_clr
);

    logic in_xfer;
    logic out_xfer;
    logic stall_evt;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign stall_evt = out_valid & ~out_ready;

    generate
        if (SKID) begin : g_skid
            skid_state_t      state_q;
            skid_state_t      state_d;
            logic             ready_q;
            logic [WIDTH-1:0] main_q;
            logic [WIDTH-1:0] skid_q;

            // in_ready is registered from the next state so it never sees same-cycle inputs
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    state_q <= ST_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != ST_TWO);
                end
            end

            always_comb begin
                state_d = state_q;
                if (flush) begin
                    state_d = ST_EMPTY;
                end else begin
                    case (state_q)
                        ST_EMPTY: if (in_xfer) state_d = ST_ONE;
                        ST_ONE: begin
                            if (in_xfer && !out_xfer)      state_d = ST_TWO;
                            else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
                        end
                        ST_TWO:   if (out_xfer) state_d = ST_ONE;
                        default:  state_d = ST_EMPTY;
                    endcase
                end
            end

            always_comb begin
                out_valid = (state_q != ST_EMPTY);
                in_ready  = ready_q;
                out_data  = main_q;
            end

            // main_q is parked at NOP_VALUE whenever the block is empty
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    main_q <= NOP_VALUE;
                    skid_q <= NOP_VALUE;
                end else if (flush) begin
                    main_q <= NOP_VALUE;
                    skid_q <= NOP_VALUE;
                end else begin
                    case (state_q)
                        ST_EMPTY: if (in_xfer) main_q <= in_data;
                        ST_ONE: begin
                            if (in_xfer && out_xfer) main_q <= in_data;
                            else if (in_xfer)        skid_q <= in_data;
                            else if (out_xfer)       main_q <= NOP_VALUE;
                        end
                        ST_TWO: begin
                            if (out_xfer) begin
                                main_q <= skid_q;
                                skid_q <= NOP_VALUE;
                            end
                        end
                        default: begin
                            main_q <= NOP_VALUE;
                            skid_q <= NOP_VALUE;
                        end
                    endcase
                end
            end
        end else begin : g_single
            logic             valid_q;
            logic [WIDTH-1:0] main_q;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    valid_q <= 1'b0;
                    main_q  <= NOP_VALUE;
                end else if (flush) begin
                    valid_q <= 1'b0;
                    main_q  <= NOP_VALUE;
                end else if (in_xfer) begin
                    valid_q <= 1'b1;
                    main_q  <= in_data;
                end else if (out_xfer) begin
                    valid_q <= 1'b0;
                    main_q  <= NOP_VALUE;
                end
            end

            assign out_valid = valid_q;
            assign out_data  = main_q;
            assign in_ready  = ~valid_q | out_ready;
        end
    endgenerate

    pipe_stall_counter #(
        .STALL_CNT_W(STALL_CNT_W)
    ) u_stall_counter (
        .CLK  (CLK),
        .RST_N(RST_N),
        .stall(stall_evt),
        .clr  (stall_clr),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Scoreboard bench: a skid instance (3-bit stall counter) and a single-entry instance share stimulus,
// each checked against a queue-based model of the accepted payloads.
module tb_pipeline_stage_register;

    localparam int W = 40;
    localparam logic [W-1:0] NOP = '0;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         flush = 1'b0;
    logic         stall_clr = 1'b0;

    logic         rdy0, ov0, rdy1, ov1;
    logic [W-1:0] od0, od1;
    logic [2:0]   sc0;
    logic [7:0]   sc1;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq0[$];
    logic [W-1:0] mq1[$];
    int ms0 = 0;
    int ms1 = 0;

    always #5 CLK = ~CLK;

    pipeline_stage_register #(.WIDTH(W), .SKID(1'b1), .STALL_CNT_W(3)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .flush(flush),
        .stall_cnt(sc0), .stall_clr(stall_clr)
    );

    pipeline_stage_register #(.WIDTH(W), .SKID(1'b0), .STALL_CNT_W(8)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .flush(flush),
        .stall_cnt(sc1), .stall_clr(stall_clr)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int q_size(input int idx);
        return (idx == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [W-1:0] q_front(input int idx);
        return (idx == 0) ? mq0[0] : mq1[0];
    endfunction

    task automatic q_pop(input int idx);
        if (idx == 0) void'(mq0.pop_front());
        else          void'(mq1.pop_front());
    endtask

    task automatic q_push(input int idx, input logic [W-1:0] d);
        if (idx == 0) mq0.push_back(d);
        else          mq1.push_back(d);
    endtask

    task automatic q_clear(input int idx);
        if (idx == 0) mq0.delete();
        else          mq1.delete();
    endtask

    // One cycle of the reference model: compare what the DUT shows now, then advance to the next edge
    task automatic model_step(input int idx, input bit skid, input int cnt_max,
                              input logic rdy, input logic ov, input logic [W-1:0] od, input int sc);
        bit exp_valid, exp_rdy, in_x, out_x;
        int cnt;
        string tag;
        tag = $sformatf("dut%0d", idx);
        cnt = (idx == 0) ? ms0 : ms1;
        if (!RST_N) begin
            q_clear(idx);
            cnt = 0;
            check_output({tag, " reset out_valid"}, 64'(ov), 64'(0));
            check_output({tag, " reset out_data"}, 64'(od), 64'(NOP));
            check_output({tag, " reset stall_cnt"}, 64'(sc), 64'(0));
        end else begin
            exp_valid = (q_size(idx) > 0);
            exp_rdy   = skid ? (q_size(idx) < 2) : (q_size(idx) == 0 || out_ready);
            check_output({tag, " out_valid"}, 64'(ov), 64'(exp_valid));
            check_output({tag, " in_ready"}, 64'(rdy), 64'(exp_rdy));
            check_output({tag, " stall_cnt"}, 64'(sc), 64'(cnt));
            check_output({tag, " out_data"}, 64'(od), 64'(exp_valid ? q_front(idx) : NOP));
            out_x = exp_valid && out_ready;
            in_x  = in_valid && exp_rdy;
            if (out_x) q_pop(idx);
            if (stall_clr) cnt = 0;
            else if (exp_valid && !out_ready && cnt < cnt_max) cnt++;
            if (flush) q_clear(idx);
            else if (in_x) q_push(idx, in_data);
        end
        if (idx == 0) ms0 = cnt;
        else          ms1 = cnt;
    endtask

    always @(negedge CLK) begin
        model_step(0, 1'b1, 7, rdy0, ov0, od0, int'(sc0));
        model_step(1, 1'b0, 255, rdy1, ov1, od1, int'(sc1));
    end

    task automatic apply_stimulus(input logic iv, input logic [W-1:0] d, input logic ordy,
                                  input logic fl, input logic clr);
        @(posedge CLK);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        stall_clr = clr;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        for (int i = 1; i <= 16; i++) apply_stimulus(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
        repeat (2) apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure into the skid entry, then drain
        apply_stimulus(1'b1, W'('hA1), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, W'('hA2), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Flush while full, colliding with a new input
        apply_stimulus(1'b1, W'('hA3), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, W'('hA4), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, W'('h55), 1'b0, 1'b1, 1'b0);
        repeat (2) apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Stall counter saturation and clear-during-stall
        apply_stimulus(1'b1, W'('h77), 1'b0, 1'b0, 1'b0);
        repeat (10) apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (2) apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Accept with simultaneous drain
        apply_stimulus(1'b1, W'('h11), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, W'('h22), 1'b1, 1'b0, 1'b0);
        repeat (2) apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            apply_stimulus($urandom_range(0, 9) < 7, {$urandom(), $urandom()},
                           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                           $urandom_range(0, 19) == 0);
        end
        repeat (3) apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges while stalled
        apply_stimulus(1'b1, W'('hB1), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, W'('hB2), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        check_output("dut0 async out_valid", 64'(ov0), 64'(0));
        check_output("dut0 async stall_cnt", 64'(sc0), 64'(0));
        check_output("dut0 async out_data", 64'(od0), 64'(NOP));
        check_output("dut1 async out_valid", 64'(ov1), 64'(0));
        check_output("dut1 async stall_cnt", 64'(sc1), 64'(0));
        @(posedge CLK);
        #1 RST_N = 1'b1;

        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, W'('hC0 + i), 1'b1, 1'b0, 1'b0);
        repeat (3) apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        @(posedge CLK);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_register.md
Name: pipeline_stage_register

Overview:
- Parametrised, handshaked pipeline register for the control/data bundle passed between pipeline stages (e.g. decode -> execute).
- Replaces fixed free-running per-signal latches with one packed payload bus.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, flush-to-bubble and a saturating stall counter.
- One instance sits between each pair of adjacent stages.

Parameters:
- WIDTH, 40, payload width in bits; the packed control bundle, LSB-aligned.
- NOP_VALUE, {WIDTH{1'b0}}, payload driven when no valid entry is held (bubble encoding).
- SKID, 1. When 1: 2-entry skid buffer with registered in_ready. When 0: single entry with combinational in_ready.
- STALL_CNT_W, 8, width of the stall counter.

Ports:
- CLK, input, 1, rising-edge clock.
- RST_N, input, 1, asynchronous active-low reset.
- in_valid, input, 1, upstream payload valid.
- in_ready, output, 1, block can accept this cycle.
- in_data, input, WIDTH, upstream payload.
- out_valid, output, 1, downstream payload valid.
- out_ready, input, 1, downstream accepts this cycle.
- out_data, output, WIDTH, downstream payload; NOP_VALUE when out_valid=0.
- flush, input, 1, synchronous kill of all held entries.
- stall_cnt, output, STALL_CNT_W, saturating count of cycles with out_valid=1 and out_ready=0.
- stall_clr, input, 1, synchronous clear of stall_cnt.

Behaviour:
- Transfers:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
  - in_data is ignored when in_valid=0.
- Reset (RST_N low, asynchronous):
  - out_valid=0, out_data=NOP_VALUE, stall_cnt=0, both entries empty.
  - in_ready=1 once RST_N is high.
  - Reset mid-transfer discards all held payloads; nothing is emitted.
- Latency: 1 cycle. Data accepted at edge N is on out_data after edge N, provided no older entry is pending.
- Ordering: strict FIFO; no entry is dropped or duplicated except by flush.
- out_data is always taken from the main register, never a combinational path from in_data.
- SKID=1 state machine (main entry M, skid entry S):
  - EMPTY -> ONE on input transfer.
  - ONE:
    - Input and output transfer together: stay in ONE, M loads in_data.
    - Input transfer only: -> TWO, S loads in_data.
    - Output transfer only: -> EMPTY.
  - TWO:
    - Output transfer: -> ONE, M<=S.
    - No input transfer is possible in TWO.
  - in_ready is registered. It is 1 in EMPTY and ONE, 0 in TWO.
  - in_ready depends on no same-cycle input and has no combinational path from out_ready.
- SKID=0:
  - Single entry M.
  - in_ready = ~out_valid | out_ready (combinational).
  - Accept with simultaneous drain refills M in the same edge (full throughput).
- out_valid: 1 in ONE/TWO (SKID=1), or when M is valid (SKID=0).
- Stalled output: out_data stays stable while out_valid=1 and out_ready=0.
- Flush (synchronous, highest priority after reset):
  - At the edge, all entries are cleared, next state is EMPTY, out_data=NOP_VALUE, in_ready=1.
  - Any input transfer on the flush cycle is discarded.
  - Any output transfer on the flush cycle still counts as consumed downstream; the block does not re-emit it.
- stall_cnt:
  - Increments by 1 at each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^STALL_CNT_W-1; no wrap-around.
  - stall_clr wins over increment and sets the counter to 0.
  - flush does not clear stall_cnt.
  - A flush edge that is also a stall edge still increments stall_cnt.
- Throughput (either SKID setting): sustained 1 transfer per cycle when out_ready=1 continuously.

Decomposition:
- Shared package pipe_pkg:
  - Skid state enum: ST_EMPTY, ST_ONE, ST_TWO.
  - Localparam NOP_CTRL, the all-zero control bundle.
  - Field offset constants for the packed control bundle (ALU op, cond, writeAd, mux selects), used by stage-side pack/unpack.
- One sub-module, pipe_stall_counter: the saturating counter with clear, parametrised on STALL_CNT_W.
- Everything else stays in the top module.

Test Plan:
- Reset and throughput: hold RST_N=0, then release; stream 0x01..0x10 with out_ready=1. Expect out_valid=0 and out_data=0 during reset, in_ready=1 after release, and outputs 0x01..0x10 each one cycle after acceptance with no gaps.
- Backpressure (SKID=1):
  - Accept 0xA1, then 0xA2, with out_ready=0. Expect state TWO, in_ready=0 on the following cycle, and out_data held at 0xA1.
  - Then out_ready=1 for 2 cycles. Expect 0xA1 then 0xA2, and in_ready back to 1.
- Flush collision: in TWO, assert flush together with in_valid=1, in_data=0x55. Next cycle expect out_valid=0, out_data=NOP_VALUE, in_ready=1, and 0x55 never emitted.
- Stall counter saturation: STALL_CNT_W=3, out_valid=1, out_ready=0 for 10 cycles. Expect 1..7, then stuck at 7. Pulse stall_clr together with a stall cycle: expect 0.
- SKID=0 refill: M holds 0x11, out_ready=1, in_valid=1 with 0x22. Expect in_ready=1 combinationally, 0x22 on the next cycle and no bubble.
- Async reset mid-stall: in state TWO, drop RST_N between clock edges. Expect out_valid and stall_cnt to go to 0 immediately, before the next edge.
